// File: rtl/codec_cfg_seq.sv
// codec_cfg_seq: boot-time WM8731 configuration sequencer feeding an I2C master's DATA/GO pair.
// Writes an 11-entry register table with per-entry NACK/timeout retries and sticky done/error.
module codec_cfg_seq #(
    parameter logic [7:0] DEV_ADDR       = 8'h34,
    parameter int         NUM_REGS       = 11,
    parameter int         MAX_RETRY      = 3,
    parameter int         SETTLE_CYCLES  = 50000,
    parameter int         TIMEOUT_CYCLES = 2000000,
    parameter bit         AUTO_START     = 1'b1
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic        start,
    input  logic        i2c_end,
    input  logic        i2c_ack,
    output logic [23:0] i2c_data,
    output logic        i2c_go,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [3:0]  reg_index
);

    localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [CNT_W-1:0]   SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);
    localparam logic [3:0]         LAST_INDEX   = 4'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        IDLE, SETTLE, WAIT_LOW, WAIT_HIGH, CHECK, FAIL, NEXT
    } state_t;

    // NOTE: the table is a constant function, i.e. ROM logic, so there is no storage to reset.
    function automatic logic [15:0] table_entry(input logic [3:0] idx);
        logic [6:0] addr;
        logic [8:0] val;
        case (idx)
            4'd0:    begin addr = 7'd15; val = 9'h000; end
            4'd1:    begin addr = 7'd0;  val = 9'h017; end
            4'd2:    begin addr = 7'd1;  val = 9'h017; end
            4'd3:    begin addr = 7'd2;  val = 9'h079; end
            4'd4:    begin addr = 7'd3;  val = 9'h079; end
            4'd5:    begin addr = 7'd4;  val = 9'h012; end
            4'd6:    begin addr = 7'd5;  val = 9'h000; end
            4'd7:    begin addr = 7'd6;  val = 9'h000; end
            4'd8:    begin addr = 7'd7;  val = 9'h00A; end
            4'd9:    begin addr = 7'd8;  val = 9'h000; end
            default: begin addr = 7'd9;  val = 9'h001; end
        endcase
        return {addr, val};
    endfunction

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [RETRY_W-1:0]   retry;
    logic [1:0]           end_sync, ack_sync, start_sync;
    logic                 start_prev;
    logic                 auto_pending;
    logic                 end_s, ack_s, start_edge, launch;
    logic                 go_nxt, busy_nxt, load_frame;
    logic [3:0]           frame_index;

    // NOTE: non-blocking assignments so every flop samples the values from before the edge.
    // END resets high so the handshake never sees a phantom "transfer started".
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            end_sync     <= 2'b11;
            ack_sync     <= 2'b00;
            start_sync   <= 2'b00;
            start_prev   <= 1'b0;
            auto_pending <= AUTO_START;
        end else begin
            end_sync     <= {end_sync[0], i2c_end};
            ack_sync     <= {ack_sync[0], i2c_ack};
            start_sync   <= {start_sync[0], start};
            start_prev   <= start_sync[1];
            auto_pending <= 1'b0;
        end
    end

    assign end_s      = end_sync[1];
    assign ack_s      = ack_sync[1];
    assign start_edge = start_sync[1] & ~start_prev;
    assign launch     = start_edge | auto_pending;

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (launch) state_nxt = SETTLE;
            SETTLE:    if (cnt == SETTLE_LAST) state_nxt = WAIT_LOW;
            WAIT_LOW: begin
                if (!end_s)                    state_nxt = WAIT_HIGH;
                else if (cnt == TIMEOUT_LAST)  state_nxt = FAIL;
            end
            WAIT_HIGH: begin
                if (end_s)                     state_nxt = CHECK;
                else if (cnt == TIMEOUT_LAST)  state_nxt = FAIL;
            end
            CHECK:     state_nxt = ack_s ? FAIL : NEXT;
            FAIL:      state_nxt = (retry < RETRY_LIMIT) ? SETTLE : IDLE;
            NEXT:      state_nxt = (reg_index == LAST_INDEX) ? IDLE : SETTLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // GO and busy are registered from the next state so they only move on state boundaries.
    always_comb begin
        go_nxt      = (state_nxt == WAIT_LOW) || (state_nxt == WAIT_HIGH);
        busy_nxt    = (state_nxt != IDLE);
        load_frame  = (state_nxt == SETTLE) && (state != SETTLE);
        frame_index = reg_index;
        if (state == IDLE)      frame_index = 4'd0;
        else if (state == NEXT) frame_index = reg_index + 4'd1;
    end

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            cnt       <= '0;
            retry     <= '0;
            i2c_data  <= '0;
            i2c_go    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            reg_index <= '0;
        end else begin
            i2c_go <= go_nxt;
            busy   <= busy_nxt;

            // One counter serves settle and timeout; it restarts on each state change.
            if (state_nxt != state) cnt <= '0;
            else if (~&cnt)         cnt <= cnt + 1'b1;

            case (state)
                IDLE: if (launch) begin
                    reg_index <= '0;
                    retry     <= '0;
                    done      <= 1'b0;
                    error     <= 1'b0;
                end
                FAIL: begin
                    if (retry < RETRY_LIMIT) retry <= retry + 1'b1;
                    else                     error <= 1'b1;
                end
                NEXT: begin
                    retry <= '0;
                    if (reg_index == LAST_INDEX) done      <= 1'b1;
                    else                         reg_index <= reg_index + 4'd1;
                end
                default: ;
            endcase

            if (load_frame) i2c_data <= {DEV_ADDR, table_entry(frame_index)};
        end
    end

endmodule

// File: tb/tb_codec_cfg_seq.sv
// tb_codec_cfg_seq: drives codec_cfg_seq with a cycle-level I2C master model and checks the
// frame stream against a list built from the register table, plus directed status checks.
module tb_codec_cfg_seq;

    localparam int SETTLE     = 10;
    localparam int LOW_CYCLES = 100;
    localparam int MAX_RETRY  = 3;
    localparam int TO_CYCLES  = 100;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic        RESET = 1'b0, start = 1'b0, i2c_end = 1'b1, i2c_ack = 1'b0;
    logic [23:0] i2c_data;
    logic        i2c_go, busy, done, error;
    logic [3:0]  reg_index;

    logic        rst_to = 1'b0, start_to = 1'b0, end_to = 1'b1, ack_to = 1'b0;
    logic [23:0] data_to;
    logic        go_to, busy_to, done_to, error_to;
    logic [3:0]  idx_to;

    codec_cfg_seq #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(1000), .MAX_RETRY(MAX_RETRY)) u_dut (
        .clk(clk), .RESET(RESET), .start(start), .i2c_end(i2c_end), .i2c_ack(i2c_ack),
        .i2c_data(i2c_data), .i2c_go(i2c_go), .busy(busy), .done(done), .error(error),
        .reg_index(reg_index)
    );

    codec_cfg_seq #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TO_CYCLES), .MAX_RETRY(MAX_RETRY)) u_dut_to (
        .clk(clk), .RESET(rst_to), .start(start_to), .i2c_end(end_to), .i2c_ack(ack_to),
        .i2c_data(data_to), .i2c_go(go_to), .busy(busy_to), .done(done_to), .error(error_to),
        .reg_index(idx_to)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, actual, expected);
    endtask

    // Register table as the codec datasheet lists it.
    logic [6:0] t_addr [11] = '{7'd15, 7'd0, 7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd6, 7'd7, 7'd8, 7'd9};
    logic [8:0] t_val  [11] = '{9'h000, 9'h017, 9'h017, 9'h079, 9'h079, 9'h012,
                                9'h000, 9'h000, 9'h00A, 9'h000, 9'h001};

    function automatic logic [23:0] frame_of(input int i);
        return {8'h34, t_addr[i], t_val[i]};
    endfunction

    logic [23:0] exp_q[$];
    logic [23:0] log_q[$];
    int          nack_entry = -1;
    int          nack_left  = 0;

    // Expected frame order: each entry once, a NACKed entry repeated until acked or retries run out.
    task automatic plan(input int entry, input int times);
        int attempts;
        exp_q.delete();
        log_q.delete();
        for (int i = 0; i < 11; i++) begin
            attempts = 1;
            if (i == entry) attempts = (times > MAX_RETRY) ? MAX_RETRY + 1 : times + 1;
            for (int a = 0; a < attempts; a++) exp_q.push_back(frame_of(i));
            if (i == entry && times > MAX_RETRY) break;
        end
        nack_entry = entry;
        nack_left  = times;
    endtask

    int          phase  = 0;
    int          ph_cnt = 0;
    logic        go_prev = 1'b0;
    logic [23:0] cur_frame = '0;

    // Compare process and I2C master model for u_dut, stepping on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            check("done_error_exclusive", {31'd0, done & error}, 32'd0);
            if (!RESET) begin
                go_prev = 1'b0;
                phase   = 0;
                i2c_end = 1'b1;
                i2c_ack = 1'b0;
            end else begin
                if (i2c_go && !go_prev) begin
                    log_q.push_back(i2c_data);
                    if (exp_q.size() == 0) check("frame_unexpected", {8'd0, i2c_data}, 32'hFFFF_FFFF);
                    else                   check("frame", {8'd0, i2c_data}, {8'd0, exp_q.pop_front()});
                    check("go_implies_busy", {31'd0, busy}, 32'd1);
                end
                if (i2c_go && go_prev) check("data_stable", {8'd0, i2c_data}, {8'd0, cur_frame});
                if (!i2c_go && go_prev) check("go_drop_after_end", phase, 3);
                case (phase)
                    0: if (i2c_go) begin phase = 1; ph_cnt = 0; cur_frame = i2c_data; end
                    1: begin
                        ph_cnt++;
                        if (ph_cnt == 2) begin i2c_end = 1'b0; i2c_ack = 1'b0; ph_cnt = 0; phase = 2; end
                    end
                    2: begin
                        ph_cnt++;
                        if (ph_cnt == LOW_CYCLES) begin
                            i2c_end = 1'b1;
                            i2c_ack = 1'b0;
                            if (nack_entry >= 0 && nack_left > 0 && cur_frame == frame_of(nack_entry)) begin
                                i2c_ack = 1'b1;
                                nack_left--;
                            end
                            phase = 3;
                        end
                    end
                    default: if (!i2c_go) phase = 0;
                endcase
                go_prev = i2c_go;
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        repeat (4) @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_busy(input string name, input logic level, input int budget);
        int n = 0;
        while (busy !== level && n < budget) begin @(negedge clk); n++; end
        check(name, {31'd0, busy}, {31'd0, level});
    endtask

    task automatic check_end(input string tag, input logic exp_done, input logic [3:0] exp_idx);
        check({tag, "_done"},  {31'd0, done},  {31'd0, exp_done});
        check({tag, "_error"}, {31'd0, error}, {31'd0, ~exp_done});
        check({tag, "_busy"},  {31'd0, busy},  32'd0);
        check({tag, "_index"}, {28'd0, reg_index}, {28'd0, exp_idx});
        check({tag, "_frames_left"}, exp_q.size(), 0);
    endtask

    function automatic int count_frame(input logic [23:0] f);
        int c = 0;
        foreach (log_q[i]) if (log_q[i] == f) c++;
        return c;
    endfunction

    initial begin
        int n;
        int pulses;
        int width;
        logic prev;

        // Reset state, then auto-start with every frame acked.
        plan(-1, 0);
        repeat (3) @(negedge clk);
        check("rst_data",  {8'd0, i2c_data}, 32'd0);
        check("rst_go",    {31'd0, i2c_go}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_done",  {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_index", {28'd0, reg_index}, 32'd0);
        RESET = 1'b1;
        wait_busy("auto_busy_rise", 1'b1, 20);
        wait_busy("auto_busy_fall", 1'b0, 5000);
        check_end("clean", 1'b1, 4'd10);
        check("clean_count", log_q.size(), 11);
        check("clean_first", {8'd0, log_q[0]}, 32'h0034_1E00);
        check("clean_last",  {8'd0, log_q[log_q.size()-1]}, 32'h0034_1201);

        // Entry 3 NACKed twice, then acked; restart from the done state.
        plan(3, 2);
        pulse_start();
        wait_busy("nack3_busy_rise", 1'b1, 20);
        check("nack3_done_cleared", {31'd0, done}, 32'd0);
        wait_busy("nack3_busy_fall", 1'b0, 5000);
        check_end("nack3", 1'b1, 4'd10);
        check("nack3_first", {8'd0, log_q[0]}, 32'h0034_1E00);
        check("nack3_repeats", count_frame(24'h340479), 3);
        check("nack3_count", log_q.size(), 13);

        // Entry 5 NACKed on every attempt.
        plan(5, 99);
        pulse_start();
        wait_busy("nack5_busy_rise", 1'b1, 20);
        wait_busy("nack5_busy_fall", 1'b0, 5000);
        check_end("nack5", 1'b0, 4'd5);
        check("nack5_repeats", count_frame(24'h340812), 4);
        repeat (300) @(negedge clk);
        check("nack5_no_more_go", log_q.size(), 9);

        // Start pulse while busy at entry 4 must not disturb the run.
        plan(-1, 0);
        pulse_start();
        wait_busy("rerun_busy_rise", 1'b1, 20);
        check("rerun_error_cleared", {31'd0, error}, 32'd0);
        n = 0;
        while (reg_index != 4'd4 && n < 3000) begin @(negedge clk); n++; end
        check("rerun_reach_entry4", {28'd0, reg_index}, 32'd4);
        pulse_start();
        wait_busy("rerun_busy_fall", 1'b0, 5000);
        check_end("rerun", 1'b1, 4'd10);
        check("rerun_count", log_q.size(), 11);

        // Reset while the DUT waits for END to return high.
        plan(-1, 0);
        pulse_start();
        n = 0;
        while (!(phase == 2 && ph_cnt >= 50) && n < 500) begin @(negedge clk); n++; end
        check("rst_mid_reached", phase, 2);
        check("rst_mid_go_before", {31'd0, i2c_go}, 32'd1);
        @(posedge clk);
        #2 RESET = 1'b0;
        #1;
        check("rst_mid_go_async", {31'd0, i2c_go}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        plan(-1, 0);
        repeat (3) @(negedge clk);
        RESET = 1'b1;
        wait_busy("rst_mid_busy_rise", 1'b1, 20);
        wait_busy("rst_mid_busy_fall", 1'b0, 5000);
        check_end("rst_mid", 1'b1, 4'd10);
        check("rst_mid_first", {8'd0, log_q[0]}, 32'h0034_1E00);

        // END never falls: every attempt times out after TO_CYCLES in the first wait.
        pulses = 0;
        width  = 0;
        prev   = 1'b0;
        @(negedge clk);
        rst_to = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (go_to && !prev) check("to_frame", {8'd0, data_to}, 32'h0034_1E00);
            if (go_to) width++;
            if (!go_to && prev) begin
                check("to_width", width, TO_CYCLES);
                pulses++;
                width = 0;
            end
            prev = go_to;
        end
        check("to_pulses", pulses, 4);
        check("to_error", {31'd0, error_to}, 32'd1);
        check("to_done",  {31'd0, done_to}, 32'd0);
        check("to_busy",  {31'd0, busy_to}, 32'd0);
        check("to_index", {28'd0, idx_to}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
